// File: rtl/sd_card_fifo_sync_prefetch.sv
// Single-clock first-word-fall-through FIFO: registered-read RAM, one read stage and one output register.
// Define SD_FIFO_SYNC_ERR_FLAG_EN to add the sticky overflow/underflow outputs.
module sd_card_fifo_sync_prefetch #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH_WIDTH = 11,
    parameter int AF_LEVEL    = 2040,
    parameter int AE_LEVEL    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   wr_en,
    output logic                   wr_vld,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   rd_en,
    output logic                   rd_vld,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic [DEPTH_WIDTH:0]   level,
    output logic                   almost_full,
`ifdef SD_FIFO_SYNC_ERR_FLAG_EN
    output logic                   overflow,
    output logic                   underflow,
`endif
    output logic                   almost_empty
);

    localparam int CAPACITY = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0]   CAP_L   = (DEPTH_WIDTH+1)'(CAPACITY);
    localparam logic [DEPTH_WIDTH:0]   AF_L    = (DEPTH_WIDTH+1)'(AF_LEVEL);
    localparam logic [DEPTH_WIDTH:0]   AE_L    = (DEPTH_WIDTH+1)'(AE_LEVEL);
    localparam logic [DEPTH_WIDTH:0]   CNT_ONE = (DEPTH_WIDTH+1)'(1);
    localparam logic [DEPTH_WIDTH-1:0] PTR_ONE = DEPTH_WIDTH'(1);

    logic [DATA_WIDTH-1:0]  mem [CAPACITY];
    logic [DEPTH_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_WIDTH:0]   ram_cnt, ram_cnt_n, level_n;
    logic [DATA_WIDTH-1:0]  data_p1;
    logic                   vld_p1;
    logic                   push, pop, out_take, rd_issue;

    always_comb begin
        push     = wr_en & wr_vld;
        pop      = rd_en & rd_vld;
        // Output register can take a word when empty or being popped this cycle.
        out_take = ~rd_vld | rd_en;
        rd_issue = (ram_cnt != '0) & (~vld_p1 | out_take);

        level_n = level;
        if (push && !pop)
            level_n = level + CNT_ONE;
        else if (pop && !push)
            level_n = level - CNT_ONE;

        ram_cnt_n = ram_cnt;
        if (push && !rd_issue)
            ram_cnt_n = ram_cnt + CNT_ONE;
        else if (rd_issue && !push)
            ram_cnt_n = ram_cnt - CNT_ONE;
    end

    // Stage p0: RAM write and registered RAM read into the p1 holding stage.
    always_ff @(posedge clk) begin
        if (push && !rst && !clr)
            mem[wr_ptr] <= wr_data;
        if (rd_issue)
            data_p1 <= mem[rd_ptr];
    end

    // Stage p1 -> output register, pointers, occupancy and flags.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            ram_cnt      <= '0;
            level        <= '0;
            vld_p1       <= 1'b0;
            rd_vld       <= 1'b0;
            rd_data      <= '0;
            wr_vld       <= ~rst;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_issue)
                rd_ptr <= rd_ptr + PTR_ONE;
            ram_cnt <= ram_cnt_n;
            level   <= level_n;
            vld_p1  <= rd_issue | (vld_p1 & ~out_take);
            if (out_take) begin
                rd_vld <= vld_p1;
                if (vld_p1)
                    rd_data <= data_p1;
            end
            wr_vld       <= (level_n != CAP_L);
            almost_full  <= (level_n >= AF_L);
            almost_empty <= (level_n <= AE_L);
        end
    end

`ifdef SD_FIFO_SYNC_ERR_FLAG_EN
    // Sticky error flags survive a flush; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && !wr_vld)
                overflow <= 1'b1;
            if (rd_en && !rd_vld)
                underflow <= 1'b1;
        end
    end
`endif

endmodule
